// File: rtl/coax_transaction_sequencer_pkg.sv
// Shared definitions for the coax transaction sequencer: FSM state encoding
// and the status codes reported on the status output. The SPI command
// decoder imports this package to interpret status.
package coax_transaction_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_TX_WAIT,
      ST_TX_RUN,
      ST_TURNAROUND,
      ST_RX_WAIT,
      ST_RX_RUN,
      ST_DONE
   } seq_state_t;

   localparam logic [2:0] STATUS_OK       = 3'd0;
   localparam logic [2:0] STATUS_TIMEOUT  = 3'd1;
   localparam logic [2:0] STATUS_RX_ERROR = 3'd2;
   localparam logic [2:0] STATUS_ABORTED  = 3'd3;
   localparam logic [2:0] STATUS_TX_EMPTY = 3'd4;
   localparam logic [2:0] STATUS_TX_STALL = 3'd5;

   // States in which the transmitter owns the line.
   function automatic logic is_tx_phase(input seq_state_t s);
      return (s == ST_START) || (s == ST_TX_WAIT) || (s == ST_TX_RUN);
   endfunction

endpackage

// File: rtl/sequencer_timer.sv
// Loadable saturating up/down counter with a terminal flag.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load           load load_value (has priority over counting)
//   load_value     value loaded on load
//   enable         count this cycle
//   count_up       1 = increment (saturate at all-ones), 0 = decrement (stop at 0)
//   count          current counter value
//   terminal       count is at the saturation point for the current direction
module sequencer_timer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             count_up,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable) begin
         if (count_up) begin
            if (count != '1) count <= count + 1'b1;
         end else begin
            if (count != '0) count <= count - 1'b1;
         end
      end
   end

   assign terminal = count_up ? (count == '1) : (count == '0);

endmodule

// File: rtl/coax_transaction_sequencer.sv
// Sequences one half-duplex coax transaction: kick the transmitter, wait for
// TX end, hold a line turnaround with the receiver gated off, then wait for
// the response under an optional timeout.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   start_strobe, abort_strobe    transaction control from the command decoder
//   expect_response               0 = TX only (sampled with start_strobe)
//   response_timeout              RX wait limit, 0 = forever (sampled with start)
//   tx_active, tx_empty           transmitter busy / TX FIFO empty
//   tx_start_strobe, tx_reset     one-cycle transmitter controls
//   rx_active, rx_error           receiver busy / error
//   rx_enable                     receiver gate
//   busy, done_strobe             transaction in progress / finished
//   status, response_latency      result code and measured RX latency
module coax_transaction_sequencer
   import coax_transaction_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_WIDTH     = 16,
   parameter int unsigned TURNAROUND_CYCLES = 16,
   parameter int unsigned TX_START_LIMIT    = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start_strobe,
   input  logic                     abort_strobe,
   input  logic                     expect_response,
   input  logic [TIMEOUT_WIDTH-1:0] response_timeout,
   input  logic                     tx_active,
   input  logic                     tx_empty,
   output logic                     tx_start_strobe,
   output logic                     tx_reset,
   input  logic                     rx_active,
   input  logic                     rx_error,
   output logic                     rx_enable,
   output logic                     busy,
   output logic                     done_strobe,
   output logic [2:0]               status,
   output logic [TIMEOUT_WIDTH-1:0] response_latency
);

   localparam logic [TIMEOUT_WIDTH-1:0] TX_WAIT_LOAD = TIMEOUT_WIDTH'(TX_START_LIMIT - 1);
   localparam logic [TIMEOUT_WIDTH-1:0] TURN_LOAD    = TIMEOUT_WIDTH'(TURNAROUND_CYCLES - 1);

   seq_state_t               state, state_next;
   logic                     expect_q, expect_next;
   logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_next;
   logic [2:0]               status_next;
   logic [TIMEOUT_WIDTH-1:0] latency_next;
   logic                     tx_reset_next;
   logic                     timer_load, timer_enable, timer_count_up, timer_terminal;
   logic [TIMEOUT_WIDTH-1:0] timer_load_value, timer_count;
   logic                     timeout_hit;

   // One timer serves all three waits. The latency count is cleared on the
   // TURNAROUND->RX_WAIT transition rather than on TURNAROUND entry because
   // the same counter is busy timing the turnaround; the RX_WAIT view is identical.
   sequencer_timer #(.WIDTH(TIMEOUT_WIDTH)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (timer_load_value),
      .enable     (timer_enable),
      .count_up   (timer_count_up),
      .count      (timer_count),
      .terminal   (timer_terminal)
   );

   assign timeout_hit = (timeout_q != '0) && (timer_count == timeout_q);

   always_comb begin
      state_next    = state;
      expect_next   = expect_q;
      timeout_next  = timeout_q;
      status_next   = status;
      latency_next  = response_latency;
      tx_reset_next = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start_strobe) begin
               latency_next = '0;
               if (tx_empty) begin
                  state_next  = ST_DONE;
                  status_next = STATUS_TX_EMPTY;
               end else begin
                  state_next   = ST_START;
                  status_next  = STATUS_OK;
                  expect_next  = expect_response;
                  timeout_next = response_timeout;
               end
            end
         end
         ST_START: state_next = ST_TX_WAIT;
         ST_TX_WAIT: begin
            if (tx_active) begin
               state_next = ST_TX_RUN;
            end else if (timer_terminal) begin
               state_next  = ST_DONE;
               status_next = STATUS_TX_STALL;
            end
         end
         ST_TX_RUN: begin
            if (!tx_active) begin
               if (expect_q) begin
                  state_next = ST_TURNAROUND;
               end else begin
                  state_next  = ST_DONE;
                  status_next = STATUS_OK;
               end
            end
         end
         ST_TURNAROUND: begin
            if (timer_terminal) state_next = ST_RX_WAIT;
         end
         ST_RX_WAIT: begin
            // rx_active is tested first so it wins a same-cycle timeout hit.
            if (rx_active) begin
               state_next   = ST_RX_RUN;
               latency_next = timer_count;
            end else if (timeout_hit) begin
               state_next   = ST_DONE;
               status_next  = STATUS_TIMEOUT;
               latency_next = '1;
            end
         end
         ST_RX_RUN: begin
            if (rx_error || !rx_active) begin
               state_next  = ST_DONE;
               status_next = rx_error ? STATUS_RX_ERROR : STATUS_OK;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // Abort overrides whatever the state logic decided this cycle.
      if (abort_strobe && (state != ST_IDLE) && (state != ST_DONE)) begin
         state_next    = ST_DONE;
         status_next   = STATUS_ABORTED;
         latency_next  = response_latency;
         tx_reset_next = is_tx_phase(state);
      end

      timer_enable   = (state == ST_TX_WAIT) || (state == ST_TURNAROUND) || (state == ST_RX_WAIT);
      timer_count_up = (state == ST_RX_WAIT);
      timer_load     = 1'b0;
      timer_load_value = '0;
      if (state_next != state) begin
         case (state_next)
            ST_TX_WAIT:    begin timer_load = 1'b1; timer_load_value = TX_WAIT_LOAD; end
            ST_TURNAROUND: begin timer_load = 1'b1; timer_load_value = TURN_LOAD;    end
            ST_RX_WAIT:    begin timer_load = 1'b1; timer_load_value = '0;           end
            default:       timer_load = 1'b0;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         expect_q         <= 1'b0;
         timeout_q        <= '0;
         status           <= STATUS_OK;
         response_latency <= '0;
         tx_start_strobe  <= 1'b0;
         tx_reset         <= 1'b0;
         rx_enable        <= 1'b1;
         busy             <= 1'b0;
         done_strobe      <= 1'b0;
      end else begin
         state            <= state_next;
         expect_q         <= expect_next;
         timeout_q        <= timeout_next;
         status           <= status_next;
         response_latency <= latency_next;
         tx_start_strobe  <= (state_next == ST_START);
         tx_reset         <= tx_reset_next;
         rx_enable        <= !(is_tx_phase(state_next) || (state_next == ST_TURNAROUND));
         busy             <= (state_next != ST_IDLE);
         done_strobe      <= (state_next == ST_DONE);
      end
   end

endmodule

// File: tb/tb_coax_transaction_sequencer.sv
module tb_coax_transaction_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_strobe, abort_strobe, expect_response;
   logic [15:0] response_timeout;
   logic        tx_active, tx_empty, tx_start_strobe, tx_reset;
   logic        rx_active, rx_error, rx_enable;
   logic        busy, done_strobe;
   logic [2:0]  status;
   logic [15:0] response_latency;

   coax_transaction_sequencer #(
      .TIMEOUT_WIDTH(16),
      .TURNAROUND_CYCLES(16),
      .TX_START_LIMIT(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .start_strobe(start_strobe), .abort_strobe(abort_strobe),
      .expect_response(expect_response), .response_timeout(response_timeout),
      .tx_active(tx_active), .tx_empty(tx_empty),
      .tx_start_strobe(tx_start_strobe), .tx_reset(tx_reset),
      .rx_active(rx_active), .rx_error(rx_error), .rx_enable(rx_enable),
      .busy(busy), .done_strobe(done_strobe),
      .status(status), .response_latency(response_latency)
   );

   always #5 clk = ~clk;

   // -1 in any metric field means "not checked for this transaction".
   typedef struct {
      int st; int lat; int starts; int resets; int rx_off;
      int turn; int fall_gap; int abort_gap; int rxw;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done_total = 0;

   task automatic check(input string nm, input longint act, input longint want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, want);
      end
   endtask

   function automatic exp_t mk(input int st, input int lat, input int starts, input int resets);
      exp_t e;
      e.st = st; e.lat = lat; e.starts = starts; e.resets = resets;
      e.rx_off = -1; e.turn = -1; e.fall_gap = -1; e.abort_gap = -1; e.rxw = -1;
      return e;
   endfunction

   // Monitor: accumulates per-transaction observations, compares on done_strobe.
   int   m_start, m_reset, m_rxoff, m_turn, m_rxw, m_rxtx, fall_gap, abort_gap;
   logic prev_tx;
   exp_t e_m;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_start = 0; m_reset = 0; m_rxoff = 0; m_turn = 0; m_rxw = 0; m_rxtx = 0;
         fall_gap = -1; abort_gap = -1; prev_tx = 1'b0;
      end else begin
         if (fall_gap >= 0) fall_gap++;
         if (abort_gap >= 0) abort_gap++;
         if (prev_tx && !tx_active) fall_gap = 0;
         if (abort_strobe && abort_gap < 0) abort_gap = 0;
         prev_tx = tx_active;
         if (tx_start_strobe) m_start++;
         if (tx_reset) m_reset++;
         if (!rx_enable) m_rxoff++;
         if (!rx_enable && fall_gap >= 1) m_turn++;
         if (rx_enable && busy && !done_strobe) m_rxw++;
         if (rx_enable && tx_active) m_rxtx++;
         if (done_strobe) begin
            done_total++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e_m = exp_q.pop_front();
               check("status", status, e_m.st);
               check("latency", response_latency, e_m.lat);
               check("tx_start_count", m_start, e_m.starts);
               check("tx_reset_count", m_reset, e_m.resets);
               check("rx_on_during_tx", m_rxtx, 0);
               if (e_m.rx_off >= 0)    check("rx_off_cycles", m_rxoff, e_m.rx_off);
               if (e_m.turn >= 0)      check("turnaround_cycles", m_turn, e_m.turn);
               if (e_m.fall_gap >= 0)  check("done_after_tx_fall", fall_gap, e_m.fall_gap);
               if (e_m.abort_gap >= 0) check("done_after_abort", abort_gap, e_m.abort_gap);
               if (e_m.rxw >= 0)       check("rx_wait_cycles", m_rxw, e_m.rxw);
            end
            m_start = 0; m_reset = 0; m_rxoff = 0; m_turn = 0; m_rxw = 0; m_rxtx = 0;
            fall_gap = -1; abort_gap = -1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic e, input logic [15:0] t);
      expect_response  = e;
      response_timeout = t;
      start_strobe     = 1'b1;
      tick();
      start_strobe     = 1'b0;
   endtask

   task automatic run_tx(input logic e, input logic [15:0] t, input int len);
      pulse_start(e, t);
      tx_active = 1'b1;
      repeat (len) tick();
      tx_active = 1'b0;
   endtask

   task automatic wait_rx_window();
      for (int i = 0; i < 64; i++) begin
         if (rx_enable) break;
         tick();
      end
      check("rx_window_open", rx_enable, 1);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check({"drain_", nm}, exp_q.size(), 0);
      exp_q.delete();
      tick();
   endtask

   exp_t e;
   int   d0;

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      start_strobe = 1'b0; abort_strobe = 1'b0; expect_response = 1'b0;
      response_timeout = '0; tx_active = 1'b0; tx_empty = 1'b0;
      rx_active = 1'b0; rx_error = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_rx_enable", rx_enable, 1);
      check("rst_status", status, 0);
      check("rst_latency", response_latency, 0);
      check("rst_done", done_strobe, 0);
      check("rst_tx_start", tx_start_strobe, 0);
      reset_n = 1'b1;
      tick();

      // TX only, 40-cycle transmit
      e = mk(0, 0, 1, 0); e.fall_gap = 1; e.turn = 0;
      exp_q.push_back(e);
      run_tx(1'b0, 16'd0, 40);
      drain("tx_only");

      // Response: rx_active 25 cycles into RX_WAIT, 30 cycles long
      e = mk(0, 25, 1, 0); e.turn = 16;
      exp_q.push_back(e);
      run_tx(1'b1, 16'd100, 40);
      wait_rx_window();
      repeat (25) tick();
      rx_active = 1'b1;
      repeat (30) tick();
      rx_active = 1'b0;
      drain("response");

      // rx_active coincides with the timeout hit: rx_active wins
      e = mk(0, 25, 1, 0); e.turn = 16;
      exp_q.push_back(e);
      run_tx(1'b1, 16'd25, 10);
      wait_rx_window();
      repeat (25) tick();
      rx_active = 1'b1;
      repeat (5) tick();
      rx_active = 1'b0;
      drain("tie");

      // Timeout 50: decision at RX_WAIT index 50, i.e. 51 RX_WAIT cycles
      e = mk(1, 65535, 1, 0); e.rxw = 51; e.turn = 16;
      exp_q.push_back(e);
      run_tx(1'b1, 16'd50, 10);
      drain("timeout");

      // TX FIFO empty at start
      e = mk(4, 0, 0, 0);
      exp_q.push_back(e);
      tx_empty = 1'b1;
      pulse_start(1'b1, 16'd100);
      tx_empty = 1'b0;
      drain("tx_empty");

      // Transmitter never starts: 1 START + 8 TX_WAIT cycles with rx gated off
      e = mk(5, 0, 1, 0); e.rx_off = 9;
      exp_q.push_back(e);
      pulse_start(1'b0, 16'd0);
      drain("tx_stall");

      // rx_error while the response is in progress
      e = mk(2, 5, 1, 0);
      exp_q.push_back(e);
      run_tx(1'b1, 16'd100, 10);
      wait_rx_window();
      repeat (5) tick();
      rx_active = 1'b1;
      repeat (10) tick();
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      rx_active = 1'b0;
      drain("rx_error");

      // Abort during TX_RUN
      e = mk(3, 0, 1, 1); e.abort_gap = 1;
      exp_q.push_back(e);
      pulse_start(1'b1, 16'd100);
      tx_active = 1'b1;
      repeat (10) tick();
      abort_strobe = 1'b1;
      tick();
      abort_strobe = 1'b0;
      tx_active = 1'b0;
      drain("abort_tx_run");

      // Abort in the same cycle tx_active falls
      e = mk(3, 0, 1, 1); e.abort_gap = 1; e.turn = 0;
      exp_q.push_back(e);
      pulse_start(1'b1, 16'd100);
      tx_active = 1'b1;
      repeat (10) tick();
      abort_strobe = 1'b1;
      tx_active = 1'b0;
      tick();
      abort_strobe = 1'b0;
      drain("abort_with_fall");

      // Reset during RX_WAIT, then a normal transaction
      run_tx(1'b1, 16'd100, 10);
      wait_rx_window();
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_rx_enable", rx_enable, 1);
      check("midrst_status", status, 0);
      check("midrst_tx_reset", tx_reset, 0);
      tick();
      reset_n = 1'b1;
      tick();
      e = mk(0, 0, 1, 0); e.fall_gap = 1;
      exp_q.push_back(e);
      run_tx(1'b0, 16'd0, 12);
      drain("after_reset");

      // Timeout 0 waits forever; end it with an abort (no tx_reset in RX_WAIT)
      run_tx(1'b1, 16'd0, 10);
      wait_rx_window();
      d0 = done_total;
      repeat (70000) tick();
      check("no_timeout_done", done_total, d0);
      check("still_busy", busy, 1);
      e = mk(3, 0, 1, 0); e.abort_gap = 1;
      exp_q.push_back(e);
      abort_strobe = 1'b1;
      tick();
      abort_strobe = 1'b0;
      drain("abort_rx_wait");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/coax_transaction_sequencer.md
Name: coax_transaction_sequencer

Overview:
Sequences one half-duplex coax transaction on the shared TX/RX datapath: kick the TX FIFO, wait for transmit end, hold a line turnaround, then gate the receiver on and wait for the response under a timeout. Sits between the SPI command decoder (which loads the TX FIFO and issues start/abort) and the coax transmitter/receiver. Reports a one-cycle completion strobe, a status code and the measured response latency.

Parameters:
TIMEOUT_WIDTH, 16, width of the timeout/latency counters.
TURNAROUND_CYCLES, 16, cycles with the receiver gated off after tx_active falls.
TX_START_LIMIT, 8, cycles allowed for tx_active to rise after tx_start_strobe.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
start_strobe  in  1  begin a transaction (1 cycle)
abort_strobe  in  1  abandon the current transaction (1 cycle)
expect_response  in  1  sampled with start_strobe; 0 = TX only
response_timeout  in  TIMEOUT_WIDTH  cycles to wait for rx_active; 0 = wait forever; sampled with start_strobe
tx_active  in  1  transmitter busy
tx_empty  in  1  TX FIFO empty
tx_start_strobe  out  1  start transmitter (1 cycle)
tx_reset  out  1  transmitter reset pulse (1 cycle)
rx_active  in  1  receiver busy
rx_error  in  1  receiver error flag
rx_enable  out  1  receiver gate
busy  out  1  transaction in progress
done_strobe  out  1  transaction finished (1 cycle)
status  out  3  0 OK, 1 TIMEOUT, 2 RX_ERROR, 3 ABORTED, 4 TX_EMPTY, 5 TX_STALL
response_latency  out  TIMEOUT_WIDTH  cycles from RX_WAIT entry to rx_active rise, saturating

Behaviour:
- All outputs are registered. Reset values: state IDLE, rx_enable 1, status 0, response_latency 0, all other outputs 0.
- States: IDLE, START, TX_WAIT, TX_RUN, TURNAROUND, RX_WAIT, RX_RUN, DONE.
- IDLE: start_strobe with tx_empty=1 goes to DONE with status TX_EMPTY. start_strobe with tx_empty=0 latches expect_response and response_timeout, then goes to START. busy is 1 in every state except IDLE.
- START: tx_start_strobe=1 for exactly one cycle; rx_enable=0; go to TX_WAIT.
- TX_WAIT: tx_active=1 goes to TX_RUN. After TX_START_LIMIT cycles without tx_active, go to DONE with status TX_STALL.
- TX_RUN: tx_active=0 goes to TURNAROUND if expect_response, else to DONE with status OK.
- TURNAROUND: rx_enable stays 0 for exactly TURNAROUND_CYCLES cycles, then go to RX_WAIT. Clear the latency counter on entry.
- RX_WAIT: rx_enable=1. The counter increments each cycle and saturates at all-ones.
  - rx_active=1 latches the counter into response_latency and goes to RX_RUN.
  - If the counter equals the latched timeout and the timeout is nonzero, go to DONE with status TIMEOUT and response_latency = all-ones.
  - If rx_active and the timeout hit occur in the same cycle, rx_active wins.
- RX_RUN: rx_active=0 goes to DONE with status RX_ERROR if rx_error=1 at that time, else OK. rx_error=1 while still active also goes to DONE with status RX_ERROR immediately.
- DONE: done_strobe=1 for one cycle; rx_enable=1; go to IDLE. status and response_latency hold until the next start_strobe is accepted.
- abort_strobe in any non-IDLE, non-DONE state goes to DONE with status ABORTED. tx_reset pulses for 1 cycle if the abort arrives in START, TX_WAIT or TX_RUN. Abort has priority over every same-cycle transition. Abort in IDLE or DONE is ignored.
- start_strobe is ignored while busy or in DONE.
- Asynchronous reset mid-transaction returns to IDLE with reset values; no tx_reset pulse is generated.

Decomposition:
- Shared package holds the state encodings and the status code constants (STATUS_OK through STATUS_TX_STALL). The SPI command decoder exposes status and response_latency, so it needs the status constants too.
- One natural sub-module, sequencer_timer: a loadable, saturating down/up counter with a terminal flag. It is reused for the TX_START_LIMIT, TURNAROUND and response-timeout waits.

Test Plan:
- TX-only: tx_empty=0, expect_response=0, start. tx_active high for 40 cycles. Required: one tx_start_strobe, done_strobe 1 cycle after tx_active falls, status=0, rx_enable 0 throughout the TX.
- Response: expect_response=1, response_timeout=100. rx_active rises 25 cycles after turnaround ends and runs 30 cycles, rx_error=0. Required: status=0, response_latency=25, rx_enable 0 for exactly 16 cycles after TX end.
- Timeout: response_timeout=50, no rx_active. Required: done_strobe 50 cycles into RX_WAIT, status=1, response_latency=all-ones. Also run with timeout=0: no completion after 70000 cycles.
- Errors:
  - tx_empty=1 at start: immediate status=4.
  - tx_active never rises: status=5 after 8 cycles.
  - rx_error asserted mid-response: status=2.
- Abort: abort_strobe during TX_RUN. Required: tx_reset 1 cycle, status=3, done_strobe next cycle. An abort coinciding with tx_active falling still gives status=3.
- Reset: deassert reset_n during RX_WAIT. Required: immediately busy=0, rx_enable=1, status=0. The next transaction completes normally.
